// File: rtl/stopwatch_pkg.sv
// Shared types and digit constants for the stopwatch/lap timer.
// Packed BCD layout is {mt, mo, st, so, ht, ho}, with ho in the least-significant nibble.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned DEC_MAX      = 9;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned ST_IDX     = 3;
  localparam int unsigned MT_IDX     = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with a 0..MAX range. It counts up or down, and a load clamps to MAX.
// The carry and borrow outputs feed the enable of the next digit in the ripple chain.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       down,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t q,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam bcd_digit_t MaxVal = bcd_digit_t'(MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (down) begin
        q <= (q == '0) ? MaxVal : q - bcd_digit_t'(1);
      end else begin
        q <= (q == MaxVal) ? '0 : q + bcd_digit_t'(1);
      end
    end
  end

  assign carry_out  = en & ~down & (q == MaxVal);
  assign borrow_out = en & down & (q == '0);

endmodule

// File: rtl/stopwatch_lap_timer.sv
// MM:SS.hh stopwatch and count-down timer with lap freeze, preset load and done/wrap pulses.
// A prescaler divides clk down to TICK_HZ, and six ripple-chained BCD digits hold the live count.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned TICK_HZ      = 100,
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        mode_down,
  input  logic        load,
  input  logic [23:0] preset_bcd,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        done,
  output logic        wrap
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] DivLast = PW'(DIV - 1);

  state_t        state;
  logic          mode_q;
  logic [PW-1:0] presc;
  logic [23:0]   count;
  logic [23:0]   snap;
  logic [5:0]    en, carry, borrow;
  logic          in_run, load_ok, count_zero, zero_stall, tick, done_evt;
  logic          unused_top_borrow;

  assign in_run     = (state == RUN);
  assign load_ok    = load & ~in_run;
  assign count_zero = (count == 24'h000000);
  // A down-count entered at zero must stop without decrementing, so the tick is suppressed.
  assign zero_stall = in_run & mode_q & count_zero;
  assign tick       = in_run & (presc == DivLast) & ~zero_stall;
  assign done_evt   = zero_stall | (tick & mode_q & (count == 24'h000001));

  assign en = {(mode_q ? borrow[4:0] : carry[4:0]), tick};
  assign unused_top_borrow = borrow[5];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned Lim = (i == ST_IDX) ? SEC_TENS_MAX :
                                  (i == MT_IDX) ? MIN_TENS_MAX : DEC_MAX;
    bcd_digit_counter #(
      .MAX (Lim)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .clr        (clear),
      .en         (en[i]),
      .down       (mode_q),
      .load       (load_ok),
      .load_val   (preset_bcd[i*DIGIT_W +: DIGIT_W]),
      .q          (count[i*DIGIT_W +: DIGIT_W]),
      .carry_out  (carry[i]),
      .borrow_out (borrow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      presc      <= '0;
      snap       <= '0;
      lap_active <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        presc      <= '0;
        lap_active <= 1'b0;
      end else if (load_ok) begin
        // Clamping never turns a nonzero digit into zero, so the raw preset decides the state.
        state      <= (|preset_bcd) ? PAUSE : IDLE;
        presc      <= '0;
        lap_active <= 1'b0;
        mode_q     <= mode_down;
      end else begin
        if (in_run) begin
          presc <= (presc == DivLast) ? '0 : presc + PW'(1);
        end
        wrap <= carry[5];
        unique case (state)
          RUN: begin
            if (done_evt) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (start_stop) begin
              state <= PAUSE;
            end
          end
          IDLE, PAUSE: begin
            if (start_stop) begin
              state  <= RUN;
              mode_q <= mode_down;
            end
          end
          DONE: begin
            if (start_stop && !count_zero) begin
              state  <= RUN;
              mode_q <= mode_down;
            end
          end
          default: state <= IDLE;
        endcase
        if (lap && state != IDLE) begin
          lap_active <= ~lap_active;
          if (!lap_active) begin
            snap <= count;
          end
        end
      end
    end
  end

  assign running  = in_run;
  assign disp_bcd = lap_active ? snap : count;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Scenario bench for stopwatch_lap_timer with DIV=10. Inputs are driven and outputs sampled on
// the falling edge, and expected display values pass through a scoreboard queue.
module tb_stopwatch_lap_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic        mode_down = 1'b0;
  logic        load = 1'b0;
  logic [23:0] preset_bcd = '0;
  logic [23:0] disp_bcd;
  logic        running, lap_active, done, wrap;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_v;

  stopwatch_lap_timer #(
    .CLK_HZ       (1000),
    .TICK_HZ      (100),
    .MIN_TENS_MAX (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .mode_down  (mode_down),
    .load       (load),
    .preset_bcd (preset_bcd),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .done       (done),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v, input logic md);
    preset_bcd = v; mode_down = md; load = 1'b1; @(negedge clk); load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_cmp++; if (disp_bcd !== 24'h0) begin n_bad++; $display("FAIL reset_disp: got %h want 000000", disp_bcd); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++; if (lap_active !== 1'b0) begin n_bad++; $display("FAIL reset_lap: got %b want 0", lap_active); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    exp_q.push_back(24'h000100);
    pulse_ss();
    cyc(1000);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL up_1s_disp: got %h want %h", disp_bcd, exp_v); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL up_running: got %b want 1", running); end
  endtask

  task automatic test_wrap();
    int hits, at;
    hits = 0; at = 0;
    pulse_ss();
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL wrap_pause: got %b want 0", running); end
    exp_q.push_back(24'h595995);
    do_load(24'h595995, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL wrap_load: got %h want %h", disp_bcd, exp_v); end
    exp_q.push_back(24'h595999);
    exp_q.push_back(24'h000000);
    pulse_ss();
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) begin hits++; at = i; end
      if (i == 40) begin
        exp_v = exp_q.pop_front();
        n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL wrap_pre: got %h want %h", disp_bcd, exp_v); end
      end
    end
    n_cmp++; if (hits != 1 || at != 50) begin n_bad++; $display("FAIL wrap_pulse: got %0d pulses at cycle %0d want 1 at 50", hits, at); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL wrap_disp: got %h want %h", disp_bcd, exp_v); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL wrap_running: got %b want 1", running); end
  endtask

  task automatic test_count_down();
    int hits, at;
    hits = 0; at = 0;
    pulse_ss();
    exp_q.push_back(24'h000003);
    do_load(24'h000003, 1'b1);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL down_load: got %h want %h", disp_bcd, exp_v); end
    exp_q.push_back(24'h000000);
    pulse_ss();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin hits++; at = i; end
    end
    n_cmp++; if (hits != 1 || at != 30) begin n_bad++; $display("FAIL down_done: got %0d pulses at cycle %0d want 1 at 30", hits, at); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL down_disp: got %h want %h", disp_bcd, exp_v); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL down_state: got running=%b want 0", running); end
    pulse_ss();
    cyc(5);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL done_ignore_ss: got running=%b want 0", running); end
  endtask

  task automatic test_lap();
    pulse_clear();
    mode_down = 1'b0;
    exp_q.push_back(24'h000042);
    pulse_ss();
    cyc(420);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL lap_pre: got %h want %h", disp_bcd, exp_v); end
    for (int k = 0; k < 5; k++) exp_q.push_back(24'h000042);
    pulse_lap();
    n_cmp++; if (lap_active !== 1'b1) begin n_bad++; $display("FAIL lap_set: got %b want 1", lap_active); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL lap_capture: got %h want %h", disp_bcd, exp_v); end
    for (int k = 0; k < 4; k++) begin
      cyc(50);
      exp_v = exp_q.pop_front();
      n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL lap_hold%0d: got %h want %h", k, disp_bcd, exp_v); end
    end
    exp_q.push_back(24'h000062);
    pulse_lap();
    n_cmp++; if (lap_active !== 1'b0) begin n_bad++; $display("FAIL lap_release: got %b want 0", lap_active); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL lap_live: got %h want %h", disp_bcd, exp_v); end
  endtask

  task automatic test_pause_resume();
    cyc(2);
    pulse_ss();
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_state: got %b want 0", running); end
    exp_q.push_back(24'h000062);
    exp_q.push_back(24'h000062);
    exp_q.push_back(24'h000063);
    cyc(100);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL pause_hold: got %h want %h", disp_bcd, exp_v); end
    pulse_ss();
    cyc(4);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL resume_early: got %h want %h", disp_bcd, exp_v); end
    cyc(1);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL resume_tick: got %h want %h", disp_bcd, exp_v); end
  endtask

  task automatic test_clear_load();
    pulse_lap();
    clear = 1'b1; start_stop = 1'b1; @(negedge clk); clear = 1'b0; start_stop = 1'b0;
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL clr_running: got %b want 0", running); end
    n_cmp++; if (lap_active !== 1'b0) begin n_bad++; $display("FAIL clr_lap: got %b want 0", lap_active); end
    exp_q.push_back(24'h000000);
    cyc(20);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL clr_disp: got %h want %h", disp_bcd, exp_v); end
    pulse_lap();
    n_cmp++; if (lap_active !== 1'b0) begin n_bad++; $display("FAIL idle_lap_ignored: got %b want 0", lap_active); end
    exp_q.push_back(24'h005000);
    exp_q.push_back(24'h000009);
    exp_q.push_back(24'h595999);
    do_load(24'h007000, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL clamp_st: got %h want %h", disp_bcd, exp_v); end
    do_load(24'h00000C, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL clamp_ho: got %h want %h", disp_bcd, exp_v); end
    do_load(24'hFFFFFF, 1'b0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL clamp_all: got %h want %h", disp_bcd, exp_v); end
    exp_q.push_back(24'h000101);
    do_load(24'h000100, 1'b0);
    pulse_ss();
    cyc(5);
    do_load(24'h000777, 1'b0);
    cyc(4);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL load_in_run: got %h want %h", disp_bcd, exp_v); end
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL load_in_run_state: got %b want 1", running); end
  endtask

  task automatic test_zero_down();
    pulse_clear();
    mode_down = 1'b1;
    pulse_ss();
    mode_down = 1'b0;
    n_cmp++; if (running !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL zero_down_run: got run=%b done=%b want 1 0", running, done); end
    cyc(1);
    n_cmp++; if (running !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL zero_down_done: got run=%b done=%b want 0 1", running, done); end
    exp_q.push_back(24'h000000);
    cyc(1);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_down_pulse_len: got %b want 0", done); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL zero_down_disp: got %h want %h", disp_bcd, exp_v); end
  endtask

  task automatic test_rst_mid();
    pulse_clear();
    mode_down = 1'b0;
    exp_q.push_back(24'h000005);
    pulse_ss();
    cyc(55);
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_bcd !== exp_v) begin n_bad++; $display("FAIL rst_pre: got %h want %h", disp_bcd, exp_v); end
    pulse_lap();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    n_cmp++; if (disp_bcd !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: got disp=%h run=%b lap=%b want 000000 0 0", disp_bcd, running, lap_active);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_count_down();
    test_lap();
    test_pause_resume();
    test_clear_load();
    test_zero_down();
    test_rst_mid();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
